vdma_triple_buffer_ctl: RTL

Triple-buffer frame scheduler between a frame writer (capture/write DMA) and the AXI4-to-AXI4-Stream read VDMA. It rotates three frame buffers in memory so the writer never writes the buffer being displayed. It hands each completed frame to the read VDMA by driving that VDMA's parameter address and update request, and waits for the VDMA's frame-index toggle before the buffer is treated as displayed. It sits in the `aclk` domain next to the read VDMA and replaces software-driven address updates.

---
 rtl/vdma_triple_buffer_ctl_pkg.sv | 25 ++
 rtl/vdma_triple_buffer_ctl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/vdma_triple_buffer_ctl_pkg.sv
// -----------------------------------------------------------------------------
// vdma_triple_buffer_ctl_pkg
// Shared definitions for the triple-buffer frame scheduler:
//   - SLOT_W      : width of a slot number (slots 0..2)
//   - state_t     : scheduler states IDLE / READY / COMMIT
//   - third_slot  : the slot that is neither a nor b (3 - a - b)
// -----------------------------------------------------------------------------
package vdma_triple_buffer_ctl_pkg;

    localparam int SLOT_W = 2;

    typedef logic [SLOT_W-1:0] slot_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READY  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // With three slots whose numbers sum to 3, the remaining slot is 3-a-b.
    function automatic slot_t third_slot(input slot_t a, input slot_t b);
        return slot_t'(2'd3 - a - b);
    endfunction

endpackage : vdma_triple_buffer_ctl_pkg

// File: rtl/vdma_triple_buffer_ctl.sv
// -----------------------------------------------------------------------------
// vdma_triple_buffer_ctl
// Rotates three frame buffers between a frame writer and a read VDMA so the
// writer never touches the buffer on display. Completed frames are handed to
// the VDMA through rd_addr / rd_update; the VDMA frame-index toggle confirms
// that the new buffer has been picked up.
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   enable               gates wr_frame_end and the start of new commits
//   base_addr            byte address of buffer 0
//   frame_size           byte stride between buffers
//   wr_frame_end         writer finished its frame (one-cycle pulse)
//   wr_addr              address of the current write buffer (combinational)
//   rd_addr, rd_update   VDMA param_addr / ctl_update
//   rd_index             VDMA ctl_index (bit 0 used)
//   wr_buf/rd_buf/new_buf slot numbers in the W / R / N roles
//   state                0 IDLE, 1 READY, 2 COMMIT
//   drop_count           saturating count of discarded frames
// -----------------------------------------------------------------------------
module vdma_triple_buffer_ctl
    import vdma_triple_buffer_ctl_pkg::*;
#(
    parameter int AXI4_ADDR_WIDTH = 32,
    parameter int INDEX_WIDTH     = 8,
    parameter int DROP_WIDTH      = 16
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       enable,
    input  logic [AXI4_ADDR_WIDTH-1:0] base_addr,
    input  logic [AXI4_ADDR_WIDTH-1:0] frame_size,
    input  logic                       wr_frame_end,
    output logic [AXI4_ADDR_WIDTH-1:0] wr_addr,
    output logic [AXI4_ADDR_WIDTH-1:0] rd_addr,
    output logic                       rd_update,
    input  logic [INDEX_WIDTH-1:0]     rd_index,
    output logic [1:0]                 wr_buf,
    output logic [1:0]                 rd_buf,
    output logic [1:0]                 new_buf,
    output logic [1:0]                 state,
    output logic [DROP_WIDTH-1:0]      drop_count
);

    // Byte address of a slot; the sum wraps naturally at the address width.
    function automatic logic [AXI4_ADDR_WIDTH-1:0] slot_addr(
        input slot_t                      k,
        input logic [AXI4_ADDR_WIDTH-1:0] base,
        input logic [AXI4_ADDR_WIDTH-1:0] stride
    );
        logic [AXI4_ADDR_WIDTH-1:0] offs;
        case (k)
            2'd1:    offs = stride;
            2'd2:    offs = stride << 1;
            default: offs = '0;
        endcase
        return base + offs;
    endfunction

    slot_t                      w_q, w_d;
    slot_t                      r_q, r_d;
    slot_t                      n_q, n_d;
    state_t                     state_q, state_d;
    logic                       rd_update_q, rd_update_d;
    logic [AXI4_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                       prev_idx_q;
    logic [DROP_WIDTH-1:0]      drop_q, drop_d;

    logic tgl;
    logic frame_evt;
    logic drop_inc;

    assign tgl       = rd_index[0] != prev_idx_q;
    assign frame_evt = enable & wr_frame_end;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_q         <= 2'd0;
            r_q         <= 2'd1;
            n_q         <= 2'd2;
            state_q     <= ST_IDLE;
            rd_update_q <= 1'b0;
            rd_addr_q   <= '0;
            prev_idx_q  <= 1'b0;
            drop_q      <= '0;
        end else begin
            w_q         <= w_d;
            r_q         <= r_d;
            n_q         <= n_d;
            state_q     <= state_d;
            rd_update_q <= rd_update_d;
            rd_addr_q   <= rd_addr_d;
            prev_idx_q  <= rd_index[0];
            drop_q      <= drop_d;
        end
    end

    always_comb begin
        w_d         = w_q;
        r_d         = r_q;
        n_d         = n_q;
        state_d     = state_q;
        rd_update_d = rd_update_q;
        rd_addr_d   = rd_addr_q;
        drop_inc    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_evt) begin
                    n_d     = w_q;
                    w_d     = third_slot(w_q, r_q);
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (frame_evt) begin
                    // Newer frame replaces the pending one; writer reuses the
                    // slot that held the discarded frame.
                    n_d      = w_q;
                    w_d      = n_q;
                    drop_inc = 1'b1;
                end else if (enable) begin
                    rd_addr_d   = slot_addr(n_q, base_addr, frame_size);
                    rd_update_d = 1'b1;
                    state_d     = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                // Completion on the toggle is not gated by enable.
                if (tgl) begin
                    r_d         = n_q;
                    rd_update_d = 1'b0;
                    if (frame_evt) begin
                        // Toggle first, then the IDLE hand-off: the freed
                        // slot is the old R.
                        n_d     = w_q;
                        w_d     = r_q;
                        state_d = ST_READY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (frame_evt) begin
                    // No free slot: the writer overwrites its own buffer.
                    drop_inc = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rd_update_d = 1'b0;
            end
        endcase

        drop_d = drop_q;
        if (drop_inc && (drop_q != {DROP_WIDTH{1'b1}}))
            drop_d = drop_q + 1'b1;
    end

    assign wr_addr    = slot_addr(w_q, base_addr, frame_size);
    assign rd_addr    = rd_addr_q;
    assign rd_update  = rd_update_q;
    assign wr_buf     = w_q;
    assign rd_buf     = r_q;
    assign new_buf    = n_q;
    assign state      = state_q;
    assign drop_count = drop_q;

endmodule : vdma_triple_buffer_ctl
